// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, address adder and the
// pipeline registers feeding the memory/writeback stages.
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [5:0]  E_Control,
    input  logic [1:0]  W_Control_in,
    input  logic        Mem_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    input  logic        bypass_alu_1,
    input  logic        bypass_alu_2,
    input  logic        bypass_mem_1,
    input  logic        bypass_mem_2,
    input  logic [15:0] Mem_Bypass_Val,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [1:0]  W_Control_out,
    output logic        Mem_Control_out,
    output logic [15:0] M_Data,
    output logic [2:0]  dr,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] IR_Exec,
    output logic [2:0]  NZP
);

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;

    logic [3:0]    opcode;
    logic [1:0]    alu_control;
    logic [1:0]    pcselect1;
    logic          pcselect2;
    logic          op2select;

    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] addr_base;
    logic [DW-1:0] addr_off;
    logic [DW-1:0] addr_res;
    logic [DW-1:0] aluout_next;
    logic [RW-1:0] nzp_next;
    logic          is_alu_op;

    assign opcode      = IR[15:12];
    assign alu_control = E_Control[5:4];
    assign pcselect1   = E_Control[3:2];
    assign pcselect2   = E_Control[1];
    assign op2select   = E_Control[0];

    // Register specifiers for the register file read, straight from IR.
    always_comb begin
        sr1 = IR[8:6];
        sr2 = IR[2:0];
        if (opcode == 4'b0011 || opcode == 4'b0111 || opcode == 4'b1011) begin
            sr2 = IR[11:9];
        end
    end

    // Operand forwarding; own ALU result has priority over memory stage.
    always_comb begin
        op1 = VSR1;
        op2 = VSR2;
        if (bypass_alu_1) begin
            op1 = aluout;
        end else if (bypass_mem_1) begin
            op1 = Mem_Bypass_Val;
        end
        if (bypass_alu_2) begin
            op2 = aluout;
        end else if (bypass_mem_2) begin
            op2 = Mem_Bypass_Val;
        end
    end

    // ALU with register or 5-bit immediate second input.
    always_comb begin
        alu_b   = op2select ? op2 : {{(DW-5){IR[4]}}, IR[4:0]};
        alu_res = '0;
        case (alu_control)
            2'b00:   alu_res = DW'(op1 + alu_b);
            2'b01:   alu_res = op1 & alu_b;
            2'b10:   alu_res = ~op1;
            default: alu_res = op1;
        endcase
    end

    // Address adder for branch, jump and memory targets.
    always_comb begin
        addr_base = pcselect2 ? npc_in : op1;
        addr_off  = '0;
        case (pcselect1)
            2'b00:   addr_off = {{(DW-11){IR[10]}}, IR[10:0]};
            2'b01:   addr_off = {{(DW-9){IR[8]}}, IR[8:0]};
            2'b10:   addr_off = {{(DW-6){IR[5]}}, IR[5:0]};
            default: addr_off = '0;
        endcase
        addr_res = DW'(addr_base + addr_off);
    end

    // Result select and branch condition mask for the next capture.
    always_comb begin
        is_alu_op   = (opcode == 4'b0001) || (opcode == 4'b0101) || (opcode == 4'b1001);
        aluout_next = is_alu_op ? alu_res : addr_res;
        nzp_next    = '0;
        if (opcode == 4'b0000) begin
            nzp_next = IR[11:9];
        end else if (opcode == 4'b1100) begin
            nzp_next = 3'b111;
        end
    end

    // Pipeline registers, loaded on enable and cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluout          <= '0;
            pcout           <= '0;
            M_Data          <= '0;
            IR_Exec         <= '0;
            dr              <= '0;
            NZP             <= '0;
            W_Control_out   <= '0;
            Mem_Control_out <= 1'b0;
        end else if (enable_execute) begin
            aluout          <= aluout_next;
            pcout           <= addr_res;
            M_Data          <= op2;
            IR_Exec         <= IR;
            dr              <= IR[11:9];
            NZP             <= nzp_next;
            W_Control_out   <= W_Control_in;
            Mem_Control_out <= Mem_Control_in;
        end
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 enable_execute  in  1  1 = capture the current instruction into the output registers this cycle.
REQ-004 IR  in  16  instruction from the decode stage.
REQ-005 npc_in  in  16  PC+1 of the instruction from the decode stage.
REQ-006 E_Control  in  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select.
REQ-007 W_Control_in  in  2  writeback control, passed through registered.
REQ-008 Mem_Control_in  in  1  memory control, passed through registered.
REQ-009 VSR1  in  16  register-file value of sr1.
REQ-010 VSR2  in  16  register-file value of sr2.
REQ-011 bypass_alu_1  in  1  operand 1 takes this block's own aluout register.
REQ-012 bypass_alu_2  in  1  operand 2 takes this block's own aluout register.
REQ-013 bypass_mem_1  in  1  operand 1 takes Mem_Bypass_Val.
REQ-014 bypass_mem_2  in  1  operand 2 takes Mem_Bypass_Val.
REQ-015 Mem_Bypass_Val  in  16  forwarded memory-stage data.
REQ-016 aluout  out  16  registered ALU result or effective address.
REQ-017 pcout  out  16  registered address-adder result (branch/jump/memory target).
REQ-018 W_Control_out  out  2  registered W_Control_in.
REQ-019 Mem_Control_out  out  1  registered Mem_Control_in.
REQ-020 M_Data  out  16  registered store data (bypassed operand 2).
REQ-021 dr  out  3  registered IR[11:9].
REQ-022 sr1  out  3  combinational IR[8:6] of the current input IR.
REQ-023 sr2  out  3  combinational: IR[11:9] when IR[15:12] is 0011, 0111 or 1011 (stores), else IR[2:0].
REQ-024 IR_Exec  out  16  registered IR.
REQ-025 NZP  out  3  registered branch condition mask.

Function
REQ-026 Operand 1 SHALL be: aluout if bypass_alu_1, else Mem_Bypass_Val if bypass_mem_1, else VSR1 (ALU bypass wins when both are set); operand 2 SHALL be resolved from the *_2 inputs and VSR2 the same way.
REQ-027 ALU second input SHALL be: operand 2 when op2select=1, else sign-extended IR[4:0].
REQ-028 ALU SHALL compute: alu_control 00 ADD, 01 AND, 10 NOT operand 1, 11 pass operand 1; ADD wraps modulo 2^16 with no carry out.
REQ-029 Address adder SHALL compute base + offset modulo 2^16; base = npc_in if pcselect2=1, else operand 1; offset by pcselect1: 00 sext(IR[10:0]), 01 sext(IR[8:0]), 10 sext(IR[5:0]), 11 zero.
REQ-030 On a rising edge with enable_execute=1: aluout <= ALU result if IR[15:12] is 0001, 0101 or 1001, else address-adder result; pcout <= address-adder result; M_Data <= operand 2; dr, IR_Exec, W_Control_out and Mem_Control_out are captured.
REQ-031 On the same capture edge, NZP SHALL load IR[11:9] for opcode 0000, 3'b111 for opcode 1100, and 3'b000 for all other opcodes.
REQ-032 With enable_execute=0, all registered outputs SHALL hold their values; sr1 and sr2 keep tracking IR.
REQ-033 Latency SHALL be one cycle from input capture to registered outputs; the bypass path SHALL use the aluout value registered before the current edge, with no combinational loop.

Reset
REQ-034 rst=0 SHALL immediately, without a clock edge, clear every registered output to zero (aluout, pcout, M_Data, IR_Exec = 16'h0000; dr, NZP = 3'b000; W_Control_out = 2'b00; Mem_Control_out = 0), including during active operation; the first capture SHALL occur on the first rising edge after rst returns to 1 with enable_execute=1.

Verification
REQ-035 Reset: drive rst=0 mid-stream while outputs are non-zero -> all registered outputs read 0 before the next clk edge and stay 0 while rst=0.
REQ-036 Register ADD: IR=16'h1642, VSR1=5, VSR2=7, E_Control=6'b000001, enable_execute=1 -> next cycle aluout=16'h000C, dr=3, sr1=1, sr2=2, NZP=000.
REQ-037 Immediate ADD: IR=16'h14BF, VSR1=16'h0000, E_Control=6'b000000 -> aluout=16'hFFFF; then next instruction IR=16'h14A1 (ADD #1) with bypass_alu_1=1, bypass_mem_1=1, VSR1=9, Mem_Bypass_Val=4 -> aluout=16'h0000 (ALU bypass has priority).
REQ-038 Branch: IR=16'h0403, npc_in=16'h3001, E_Control=6'b000110 -> pcout=16'h3004, aluout=16'h3004, NZP=3'b010.
REQ-039 Store source select: IR=16'h3A05 (ST R5) -> sr2=5 combinationally; with bypass_mem_2=1 and Mem_Bypass_Val=16'hBEEF -> M_Data=16'hBEEF after the edge.
REQ-040 Stall: enable_execute=0 for 3 cycles while IR, VSR1 and VSR2 change -> all registered outputs unchanged; sr1 and sr2 follow IR.
